// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Arbitrates the single register-file write port between pipeline writeback
// and the multicycle MDU. MDU results that lose to the pipeline wait in a small
// FIFO. A destination scoreboard holds decode on hazards against pending MDU
// writes. A starvation counter asks upstream for a bubble when the FIFO head
// has waited long enough.
//
// MDU handshake (valid/ready):
//   A result transfers on every rising edge where mdu_valid and mdu_ready are
//   both high. While mdu_valid is high and mdu_ready is low, the MDU holds
//   mdu_addr/mdu_data stable. mdu_ready depends only on the registered fill
//   level and on reset. It never depends on mdu_valid or on pipe_wr_en.
module rf_wb_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          pipe_wr_en,
   input  logic [4:0]                    pipe_wr_addr,
   input  logic [31:0]                   pipe_wr_data,
   input  logic                          mdu_valid,
   output logic                          mdu_ready,
   input  logic [4:0]                    mdu_addr,
   input  logic [31:0]                   mdu_data,
   input  logic                          issue_valid,
   input  logic                          issue_fire,
   input  logic                          issue_mdu,
   input  logic [4:0]                    issue_rs1,
   input  logic [4:0]                    issue_rs2,
   input  logic [4:0]                    issue_rd,
   output logic                          hazard_stall,
   output logic                          wb_stall,
   output logic                          rf_we,
   output logic [4:0]                    rf_wa,
   output logic [31:0]                   rf_wd,
   output logic [31:0]                   busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] STARVE_C = CW'(STARVE_MAX);

   // MDU result buffer (storage has no reset; validity comes from count_q)
   logic [4:0]    q_addr [FIFO_DEPTH];
   logic [31:0]   q_data [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count_q;
   logic [PW:0]   count_d;

   logic [CW-1:0] starve_q;
   logic [CW-1:0] starve_d;

   logic [31:0]   busy_q;
   logic [31:0]   busy_d;
   logic [31:0]   busy_eff;
   logic [31:0]   clr_vec;
   logic [31:0]   set_vec;

   logic          fifo_empty;
   logic          fifo_full;
   logic          pipe_win;
   logic          mdu_xfer;
   logic          mdu_bypass;
   logic          fifo_push;
   logic          fifo_pop;
   logic          mdu_wr;

   // Source decisions: pipeline first, then FIFO head, then direct bypass
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == DEPTH_C);
      mdu_ready  = RST_N & ~fifo_full;
      mdu_xfer   = mdu_valid & mdu_ready;
      // A pipe write to x0 is no write at all, so the port stays free
      pipe_win   = RST_N & pipe_wr_en & (pipe_wr_addr != 5'd0);
      fifo_pop   = ~pipe_win & ~fifo_empty;
      mdu_bypass = ~pipe_win & fifo_empty & mdu_xfer & (mdu_addr != 5'd0);
      // Results for x0 are accepted and dropped, never buffered
      fifo_push  = mdu_xfer & ~mdu_bypass & (mdu_addr != 5'd0);
   end

   // Register-file write port mux
   always_comb begin
      rf_we  = 1'b0;
      rf_wa  = '0;
      rf_wd  = '0;
      mdu_wr = 1'b0;
      if (pipe_win) begin
         rf_we = 1'b1;
         rf_wa = pipe_wr_addr;
         rf_wd = pipe_wr_data;
      end else if (fifo_pop) begin
         rf_we  = 1'b1;
         rf_wa  = q_addr[rd_ptr];
         rf_wd  = q_data[rd_ptr];
         mdu_wr = 1'b1;
      end else if (mdu_bypass) begin
         rf_we  = 1'b1;
         rf_wa  = mdu_addr;
         rf_wd  = mdu_data;
         mdu_wr = 1'b1;
      end
   end

   // FIFO occupancy update; simultaneous push and pop cancel out
   always_comb begin
      count_d = count_q;
      case ({fifo_push, fifo_pop})
         2'b10:   count_d = count_q + (PW + 1)'(1);
         2'b01:   count_d = count_q - (PW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Starvation counter: counts undrained cycles of a waiting head, saturating
   always_comb begin
      if (fifo_empty || fifo_pop) begin
         starve_d = '0;
      end else if (starve_q != STARVE_C) begin
         starve_d = starve_q + CW'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   // Scoreboard: an MDU write clears its bit, a new MDU issue sets it (set wins)
   always_comb begin
      clr_vec  = mdu_wr ? (32'd1 << rf_wa) : 32'd0;
      set_vec  = (issue_fire && issue_mdu && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
      busy_d   = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;
      // A register being written by the MDU this cycle no longer blocks decode
      busy_eff = busy_q & ~clr_vec;
   end

   // Stall outputs and visible state
   always_comb begin
      hazard_stall = issue_valid & (busy_eff[issue_rs1] | busy_eff[issue_rs2] | busy_eff[issue_rd]);
      wb_stall     = (starve_q == STARVE_C);
      busy         = busy_q;
      fifo_count   = count_q;
   end

   // Control state: pointers, occupancy, starvation counter, scoreboard
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
         starve_q <= '0;
         busy_q   <= '0;
      end else begin
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (fifo_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         count_q  <= count_d;
         starve_q <= starve_d;
         busy_q   <= busy_d;
      end
   end

   // FIFO storage write
   always_ff @(posedge CLK) begin
      if (fifo_push) begin
         q_addr[wr_ptr] <= mdu_addr;
         q_data[wr_ptr] <= mdu_data;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios followed by a randomized
// run checked against a queue-based behavioural model.
module tb_rf_wb_arbiter;

   localparam int FIFO_DEPTH = 2;
   localparam int STARVE_MAX = 4;

   // ---------------- clock / reset / DUT ----------------
   logic        CLK = 1'b0;
   logic        RST_N;
   logic        pipe_wr_en;
   logic [4:0]  pipe_wr_addr;
   logic [31:0] pipe_wr_data;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic        issue_valid;
   logic        issue_fire;
   logic        issue_mdu;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic [4:0]  issue_rd;
   logic        hazard_stall;
   logic        wb_stall;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [31:0] busy;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   rf_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
      .issue_valid(issue_valid), .issue_fire(issue_fire), .issue_mdu(issue_mdu),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
      .hazard_stall(hazard_stall), .wb_stall(wb_stall),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .busy(busy), .fifo_count(fifo_count)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        m_q[$];      // buffered MDU results, oldest first
   bit   [31:0] m_busy;      // registers waiting on an MDU result
   int          m_wait;      // cycles the current head has gone undrained

   logic        e_we;
   logic [4:0]  e_wa;
   logic [31:0] e_wd;
   logic        e_src_mdu;
   logic        e_pop;
   logic        e_push;
   logic [4:0]  e_push_a;
   logic [31:0] e_push_d;
   logic        e_ready;
   logic        e_xfer;
   logic        e_hazard;
   logic        e_wbstall;

   function automatic bit still_pending(logic [4:0] r);
      return m_busy[r] && !(e_src_mdu && e_wa == r);
   endfunction

   // Decide this cycle's expected outputs from the current inputs and model state
   task automatic model_eval();
      bit pipe_takes;
      pipe_takes = pipe_wr_en && (pipe_wr_addr != 5'd0);
      e_ready    = (m_q.size() < FIFO_DEPTH);
      e_xfer     = mdu_valid && e_ready;
      e_we = 1'b0; e_wa = '0; e_wd = '0; e_src_mdu = 1'b0; e_pop = 1'b0; e_push = 1'b0;
      if (pipe_takes) begin
         e_we = 1'b1; e_wa = pipe_wr_addr; e_wd = pipe_wr_data;
      end else if (m_q.size() > 0) begin
         e_we = 1'b1; e_wa = m_q[0].a; e_wd = m_q[0].d; e_src_mdu = 1'b1; e_pop = 1'b1;
      end else if (e_xfer && mdu_addr != 5'd0) begin
         e_we = 1'b1; e_wa = mdu_addr; e_wd = mdu_data; e_src_mdu = 1'b1;
      end
      // Anything accepted for a nonzero register that did not go straight to the port is queued
      e_push    = e_xfer && (mdu_addr != 5'd0) && !(e_src_mdu && !e_pop);
      e_push_a  = mdu_addr;
      e_push_d  = mdu_data;
      e_hazard  = issue_valid && (still_pending(issue_rs1) || still_pending(issue_rs2) || still_pending(issue_rd));
      e_wbstall = (m_wait >= STARVE_MAX);
   endtask

   // Advance model state at the clock edge
   task automatic model_commit();
      ent_t ent;
      if (m_q.size() == 0 || e_pop) m_wait = 0;
      else if (m_wait < STARVE_MAX) m_wait = m_wait + 1;
      if (e_pop) void'(m_q.pop_front());
      if (e_push) begin
         ent.a = e_push_a;
         ent.d = e_push_d;
         m_q.push_back(ent);
      end
      if (e_src_mdu) m_busy[e_wa] = 1'b0;
      if (issue_fire && issue_mdu && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
   endtask

   // ---------------- invariant monitor ----------------
   always @(negedge CLK) begin
      if (RST_N === 1'b1) begin
         checks++;
         if (pipe_wr_en && pipe_wr_addr != 5'd0 && busy[pipe_wr_addr]) begin
            errors++; $display("FAIL inv_pipe_busy: pipe writes x%0d while busy=%h", pipe_wr_addr, busy);
         end
         checks++;
         if (int'(fifo_count) > FIFO_DEPTH) begin
            errors++; $display("FAIL inv_fifo_count: got %0d limit %0d", fifo_count, FIFO_DEPTH);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      pipe_wr_en = 0; pipe_wr_addr = 0; pipe_wr_data = 0;
      mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
      issue_valid = 0; issue_fire = 0; issue_mdu = 0;
      issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
   endtask

   task automatic next_cycle();
      @(posedge CLK); #1;
   endtask

   task automatic apply_reset();
      idle_inputs(); RST_N = 0;
      next_cycle(); next_cycle();
      RST_N = 1;
      m_q.delete(); m_busy = 0; m_wait = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST_N = 0;
      pipe_wr_en = 1; pipe_wr_addr = 3; pipe_wr_data = 32'h1111_2222;
      mdu_valid = 1; mdu_addr = 4; mdu_data = 32'h3333_4444;
      issue_valid = 1; issue_fire = 1; issue_mdu = 1; issue_rd = 4; issue_rs1 = 4;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b exp 0", rf_we); end
      checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL reset_mdu_ready: got %b exp 0", mdu_ready); end
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b exp 0", hazard_stall); end
      checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_wb_stall: got %b exp 0", wb_stall); end
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy); end
      next_cycle();
      idle_inputs(); RST_N = 1;
      @(negedge CLK);
      checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL release_mdu_ready: got %b exp 1", mdu_ready); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL release_rf_we: got %b exp 0", rf_we); end
      next_cycle();
   endtask

   task automatic test_bypass();
      idle_inputs(); issue_valid = 1; issue_fire = 1; issue_mdu = 1; issue_rd = 5;
      next_cycle(); idle_inputs();
      @(negedge CLK);
      checks++; if (busy !== 32'h20) begin errors++; $display("FAIL bypass_busy_set: got %h exp 00000020", busy); end
      next_cycle();
      mdu_valid = 1; mdu_addr = 5; mdu_data = 32'hDEAD_BEEF;
      @(negedge CLK);
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL bypass_we: got %b exp 1", rf_we); end
      checks++; if (rf_wa !== 5'd5) begin errors++; $display("FAIL bypass_wa: got %0d exp 5", rf_wa); end
      checks++; if (rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_wd: got %h exp deadbeef", rf_wd); end
      next_cycle(); idle_inputs();
      @(negedge CLK);
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL bypass_count: got %0d exp 0", fifo_count); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL bypass_busy_clr: got %h exp 0", busy); end
      next_cycle();
   endtask

   task automatic test_fifo_order();
      idle_inputs();
      pipe_wr_en = 1; pipe_wr_addr = 3; pipe_wr_data = 32'hA5A5_0003;
      mdu_valid = 1; mdu_addr = 7; mdu_data = 32'h11;
      @(negedge CLK);
      checks++; if (rf_wa !== 5'd3 || rf_wd !== 32'hA5A5_0003) begin errors++; $display("FAIL order_pipe_wins: got x%0d=%h exp x3=a5a50003", rf_wa, rf_wd); end
      checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL order_ready0: got %b exp 1", mdu_ready); end
      next_cycle(); mdu_addr = 8; mdu_data = 32'h22;
      @(negedge CLK);
      checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL order_count1: got %0d exp 1", fifo_count); end
      next_cycle(); mdu_valid = 0;
      @(negedge CLK);
      checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL order_count2: got %0d exp 2", fifo_count); end
      checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL order_full_ready: got %b exp 0", mdu_ready); end
      next_cycle(); pipe_wr_en = 0;
      @(negedge CLK);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h11) begin errors++; $display("FAIL order_first: got we=%b x%0d=%h exp x7=11", rf_we, rf_wa, rf_wd); end
      next_cycle();
      @(negedge CLK);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd8 || rf_wd !== 32'h22) begin errors++; $display("FAIL order_second: got we=%b x%0d=%h exp x8=22", rf_we, rf_wa, rf_wd); end
      next_cycle();
      @(negedge CLK);
      checks++; if (rf_we !== 1'b0 || fifo_count !== '0) begin errors++; $display("FAIL order_empty: got we=%b count=%0d exp 0/0", rf_we, fifo_count); end
      next_cycle();
   endtask

   task automatic test_starvation();
      idle_inputs();
      pipe_wr_en = 1; pipe_wr_addr = 3; pipe_wr_data = 32'h3;
      mdu_valid = 1; mdu_addr = 10; mdu_data = 32'h55;
      next_cycle(); mdu_valid = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         checks++;
         if (wb_stall !== (k >= STARVE_MAX)) begin
            errors++; $display("FAIL starve_wait%0d: got %b exp %b", k, wb_stall, (k >= STARVE_MAX));
         end
         next_cycle();
      end
      pipe_wr_en = 0;
      @(negedge CLK);
      checks++; if (rf_wa !== 5'd10 || rf_wd !== 32'h55) begin errors++; $display("FAIL starve_drain: got x%0d=%h exp x10=55", rf_wa, rf_wd); end
      next_cycle();
      @(negedge CLK);
      checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_fall: got %b exp 0", wb_stall); end
      next_cycle();
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      issue_valid = 1; issue_fire = 1; issue_mdu = 1; issue_rd = 9; issue_rs1 = 1; issue_rs2 = 2;
      next_cycle();
      issue_fire = 0; issue_mdu = 0;
      for (int k = 0; k < 3; k++) begin
         issue_rs1 = (k == 0) ? 5'd9 : 5'd2;
         issue_rs2 = (k == 1) ? 5'd9 : 5'd2;
         issue_rd  = (k == 2) ? 5'd9 : 5'd1;
         @(negedge CLK);
         checks++; if (busy !== 32'h200) begin errors++; $display("FAIL sb_busy%0d: got %h exp 00000200", k, busy); end
         checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL sb_hazard%0d: got %b exp 1", k, hazard_stall); end
         next_cycle();
      end
      issue_rs1 = 9; issue_rs2 = 2; issue_rd = 1;
      mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h99;
      @(negedge CLK);
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL sb_release: got %b exp 0", hazard_stall); end
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd9) begin errors++; $display("FAIL sb_write: got we=%b x%0d exp x9", rf_we, rf_wa); end
      next_cycle(); mdu_valid = 0;
      @(negedge CLK);
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL sb_cleared: got %h exp 0", busy); end
      next_cycle();
   endtask

   task automatic test_set_wins();
      idle_inputs(); issue_valid = 1; issue_fire = 1; issue_mdu = 1; issue_rd = 9;
      next_cycle();
      mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h1234;
      @(negedge CLK);
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL setwins_hazard: got %b exp 0", hazard_stall); end
      next_cycle(); idle_inputs();
      @(negedge CLK);
      checks++; if (busy !== 32'h200) begin errors++; $display("FAIL setwins_busy: got %h exp 00000200", busy); end
      next_cycle();
      mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h1;
      next_cycle(); idle_inputs();
      @(negedge CLK);
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL setwins_clear: got %h exp 0", busy); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      idle_inputs(); issue_valid = 1; issue_fire = 1; issue_mdu = 1; issue_rd = 8;
      next_cycle();
      issue_rd = 9;
      pipe_wr_en = 1; pipe_wr_addr = 3; pipe_wr_data = 32'h3;
      mdu_valid = 1; mdu_addr = 8; mdu_data = 32'h88;
      next_cycle();
      issue_valid = 0; issue_fire = 0; issue_mdu = 0;
      mdu_addr = 9; mdu_data = 32'h99;
      next_cycle(); mdu_valid = 0;
      @(negedge CLK);
      checks++; if (fifo_count !== 2'd2 || busy !== 32'h300) begin errors++; $display("FAIL mid_setup: got count=%0d busy=%h exp 2/00000300", fifo_count, busy); end
      #2; RST_N = 0; #1;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_rf_we: got %b exp 0", rf_we); end
      checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b exp 0", mdu_ready); end
      next_cycle();
      RST_N = 1; idle_inputs();
      @(negedge CLK);
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL mid_count: got %0d exp 0", fifo_count); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL mid_busy: got %h exp 0", busy); end
      checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b exp 1", mdu_ready); end
      next_cycle();
   endtask

   task automatic test_random();
      bit mdu_hold;
      mdu_hold = 0;
      apply_reset();
      for (int n = 0; n < 800; n++) begin
         // pipeline writeback, mostly honouring wb_stall and never to a pending register
         pipe_wr_addr = 5'($urandom_range(0, 15));
         pipe_wr_data = $urandom;
         pipe_wr_en   = ($urandom_range(0, 9) < 6);
         if (m_wait >= STARVE_MAX && $urandom_range(0, 3) != 0) pipe_wr_en = 0;
         if (m_busy[pipe_wr_addr]) pipe_wr_en = 0;
         // MDU keeps an unaccepted result stable
         if (!mdu_hold) begin
            mdu_valid = ($urandom_range(0, 1) == 1);
            mdu_addr  = 5'($urandom_range(0, 15));
            mdu_data  = $urandom;
         end
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_mdu   = ($urandom_range(0, 1) == 1);
         issue_rs1   = 5'($urandom_range(0, 15));
         issue_rs2   = 5'($urandom_range(0, 15));
         issue_rd    = 5'($urandom_range(0, 15));
         issue_fire  = 0;
         model_eval();
         issue_fire = issue_valid && !e_hazard && ($urandom_range(0, 1) == 1);
         mdu_hold   = mdu_valid && !e_xfer;
         @(negedge CLK);
         checks++; if (rf_we !== e_we) begin errors++; $display("FAIL rnd_we c%0d: got %b exp %b", n, rf_we, e_we); end
         if (e_we) begin
            checks++; if (rf_wa !== e_wa) begin errors++; $display("FAIL rnd_wa c%0d: got %0d exp %0d", n, rf_wa, e_wa); end
            checks++; if (rf_wd !== e_wd) begin errors++; $display("FAIL rnd_wd c%0d: got %h exp %h", n, rf_wd, e_wd); end
         end
         checks++; if (mdu_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", n, mdu_ready, e_ready); end
         checks++; if (hazard_stall !== e_hazard) begin errors++; $display("FAIL rnd_hazard c%0d: got %b exp %b", n, hazard_stall, e_hazard); end
         checks++; if (wb_stall !== e_wbstall) begin errors++; $display("FAIL rnd_wb_stall c%0d: got %b exp %b", n, wb_stall, e_wbstall); end
         checks++; if (int'(fifo_count) != m_q.size()) begin errors++; $display("FAIL rnd_count c%0d: got %0d exp %0d", n, fifo_count, m_q.size()); end
         checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %h exp %h", n, busy, m_busy); end
         @(posedge CLK);
         model_commit();
         #1;
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      RST_N = 0;
      #1;
      test_reset();
      test_bypass();
      test_fifo_order();
      test_starvation();
      test_scoreboard();
      test_set_wins();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (WB stage write data) and the multicycle multiply/divide unit (MDU), whose results return asynchronously to the pipeline.
- Buffers MDU results in a small FIFO and keeps a destination-register scoreboard that stalls issue on hazards against in-flight MDU results.
- Forces a writeback bubble when a buffered MDU result has waited too long.

Parameters:
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2).
- STARVE_MAX, 4, cycles a FIFO head may wait before wb_stall is raised.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- pipe_wr_en  in  1  pipeline writeback wants to write this cycle.
- pipe_wr_addr  in  5  pipeline destination register.
- pipe_wr_data  in  32  pipeline write data (WB mux output).
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  arbiter accepts the MDU result this cycle.
- mdu_addr  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- issue_valid  in  1  an instruction is in decode.
- issue_fire  in  1  decode instruction advances this cycle.
- issue_mdu  in  1  issuing instruction goes to the MDU.
- issue_rs1  in  5  source register 1 of the decode instruction.
- issue_rs2  in  5  source register 2 of the decode instruction.
- issue_rd  in  5  destination register of the decode instruction.
- hazard_stall  out  1  decode must hold.
- wb_stall  out  1  upstream must present a bubble (pipe_wr_en=0) this cycle.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  32  register-file write data.
- busy  out  32  scoreboard, bit n = xn has a pending MDU write.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered MDU results.

Behaviour:
Reset (RST_N low, asynchronous):
- FIFO is emptied; busy=0; starve counter=0.
- While reset is asserted: rf_we=0, mdu_ready=0, hazard_stall=0, wb_stall=0.
- Any MDU operation in flight is discarded; the MDU is reset by the same reset.

Port selection (combinational, same cycle):
- Priority 1: pipe_wr_en=1 and pipe_wr_addr!=0 -> rf_we=1, rf_wa/rf_wd from pipe_*. The pipeline always wins.
- Priority 2: otherwise, if the FIFO is non-empty -> write the FIFO head and pop it.
- Priority 3: otherwise, if mdu_valid=1 -> bypass: write mdu_addr/mdu_data directly; nothing is enqueued.
- A pipe write to x0 counts as a free slot. An MDU result to x0 is accepted and dropped, with rf_we=0.
- When no source writes, rf_we=0; rf_wa and rf_wd are don't-care.

MDU handshake:
- mdu_ready = (fifo_count < FIFO_DEPTH). This is registered state only, with no combinational path from pipe_wr_en.
- Transfer occurs when mdu_valid & mdu_ready.
- A transfer that is not bypassed is enqueued at the tail.
- Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- When full, the MDU holds its result stable.

Scoreboard:
- Set busy[issue_rd] when issue_fire & issue_mdu & issue_rd!=0.
- Clear busy[n] on the cycle an MDU-sourced write to xn occurs (bypass or FIFO drain).
- Set and clear of the same register in one cycle: set wins.
- busy[0] is always 0.

Hazard stall:
- hazard_stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]). The rd term covers WAW.
- A pending MDU write is never forwarded; decode waits for it to reach the register file.

Starvation:
- The counter increments each cycle the FIFO is non-empty and the head is not drained.
- It resets to 0 on any drain and holds 0 while the FIFO is empty.
- wb_stall = (counter == STARVE_MAX).
- If pipe_wr_en=1 anyway while wb_stall=1, the pipeline still wins, the counter saturates at STARVE_MAX, and wb_stall stays high.
- Latency from the starvation condition to wb_stall is exactly STARVE_MAX cycles.

Invariants (bench assertions):
- Never a pipe write to xn while busy[n]=1.
- fifo_count <= FIFO_DEPTH.
- At most one RF write per cycle.

Test Plan:
- Idle port, mdu_valid=1, mdu_addr=5, mdu_data=0xDEADBEEF -> same cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; fifo_count stays 0; busy[5] cleared.
- pipe_wr_en=1 continuously (addr 3), two MDU results (x7=0x11, x8=0x22) -> fifo_count=2, mdu_ready=0; after the pipe drops, the writes occur in order x7 then x8 on consecutive cycles.
- FIFO holding one entry plus a continuous pipe write -> wb_stall rises exactly STARVE_MAX=4 cycles later. A pipe bubble drains the head and wb_stall falls the next cycle.
- Issue MDU op rd=9 (issue_fire, issue_mdu) -> busy[9]=1. Next instruction with rs1=9 -> hazard_stall=1 until the x9 MDU write, then 0 the same cycle the write occurs.
- MDU write to x9 in the same cycle as a new MDU issue with rd=9 -> busy[9] remains 1.
- Assert RST_N low mid-operation with fifo_count=2 and busy=0x300 -> immediately rf_we=0 and mdu_ready=0. After release: fifo_count=0, busy=0, mdu_ready=1.
